// File: rtl/acoustics_uart_pkg.sv
// Shared definitions for the topside UART output path.
package acoustics_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
    localparam int unsigned UART_DATA_BITS       = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_counter
    import acoustics_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // Free-running count within a bit, wrapping on terminal count; held at 0 while cleared.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Two-frame 8N1 transmitter for one frozen 16-bit word, high byte first.
module uart_word_tx
    import acoustics_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_req,
    input  logic [7:0] word_byte,
    output logic       hold_data_sel,
    output logic       byte_to_send_sel,
    output logic       busy,
    output logic       done,
    output logic       uart_tx
);

    tx_state_t                 state;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [2:0]                bit_idx;
    logic                      byte_idx;
    logic                      baud_clear;
    logic                      baud_tick;

    // Every START/DATA/STOP exit happens on terminal count, where the counter
    // wraps anyway, so clearing only in IDLE/LOAD resets it on each state change.
    assign baud_clear = (state == IDLE) || (state == LOAD);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    // Transfer sequencer with registered line and datapath controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            shift_reg        <= '0;
            bit_idx          <= '0;
            byte_idx         <= 1'b0;
            uart_tx          <= LINE_IDLE;
            hold_data_sel    <= 1'b0;
            byte_to_send_sel <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_tx <= LINE_IDLE;
                    if (send_req) begin
                        state            <= LOAD;
                        byte_idx         <= 1'b0;
                        hold_data_sel    <= 1'b1;
                        byte_to_send_sel <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                LOAD: begin
                    shift_reg <= word_byte;
                    bit_idx   <= '0;
                    uart_tx   <= LINE_START;
                    state     <= START;
                end
                START: begin
                    if (baud_tick) begin
                        uart_tx <= shift_reg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            uart_tx <= LINE_STOP;
                            state   <= STOP;
                        end else begin
                            shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
                            uart_tx   <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (!byte_idx) begin
                            byte_idx         <= 1'b1;
                            byte_to_send_sel <= 1'b0;
                            state            <= LOAD;
                        end else begin
                            state         <= IDLE;
                            done          <= 1'b1;
                            hold_data_sel <= 1'b0;
                            busy          <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
